// File: rtl/inst_fetcher.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line icache,
// miss refill through memCtrl and a one-entry valid/ready output register to decode.
module inst_fetcher #(
    parameter int unsigned ICACHE_IDX_W = 8,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [31:0] rob_to_if_pc,
    output logic        if_to_mc_enable,
    output logic [31:0] if_to_mc_pc,
    input  logic        mc_to_if_done,
    input  logic [31:0] mc_to_if_result,
    output logic        if_to_dec_valid,
    output logic [31:0] if_to_dec_inst,
    output logic [31:0] if_to_dec_pc,
    input  logic        dec_to_if_ready
);

    localparam int unsigned LINES = 1 << ICACHE_IDX_W;
    localparam int unsigned TAG_W = 30 - ICACHE_IDX_W;

    localparam logic ST_LOOKUP = 1'b0;
    localparam logic ST_MISS   = 1'b1;

    logic              state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              mc_en_q, mc_en_d;
    logic [31:0]       mc_pc_q, mc_pc_d;
    logic              dec_valid_q, dec_valid_d;
    logic [31:0]       dec_inst_q, dec_inst_d;
    logic [31:0]       dec_pc_q, dec_pc_d;

    logic [LINES-1:0]  line_valid_q;
    logic [TAG_W-1:0]  line_tag_q  [LINES];
    logic [31:0]       line_data_q [LINES];

    logic [ICACHE_IDX_W-1:0] pc_idx_c, fill_idx_c;
    logic [TAG_W-1:0]        pc_tag_c, fill_tag_c;
    logic                    hit_c, free_c, fill_we_c;

    assign pc_idx_c   = pc_q[ICACHE_IDX_W+1:2];
    assign pc_tag_c   = pc_q[31:ICACHE_IDX_W+2];
    assign fill_idx_c = mc_pc_q[ICACHE_IDX_W+1:2];
    assign fill_tag_c = mc_pc_q[31:ICACHE_IDX_W+2];
    assign hit_c      = line_valid_q[pc_idx_c] && (line_tag_q[pc_idx_c] == pc_tag_c);
    assign free_c     = !dec_valid_q || dec_to_if_ready;
    // A done coinciding with a flush or a stall is dropped, never written.
    assign fill_we_c  = !rst && rdy && !clr && (state_q == ST_MISS) && mc_to_if_done;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mc_en_d     = mc_en_q;
        mc_pc_d     = mc_pc_q;
        dec_valid_d = dec_valid_q;
        dec_inst_d  = dec_inst_q;
        dec_pc_d    = dec_pc_q;
        if (clr) begin
            pc_d        = rob_to_if_pc;
            dec_valid_d = 1'b0;
            mc_en_d     = 1'b0;
            state_d     = ST_LOOKUP;
        end else begin
            if (dec_valid_q && dec_to_if_ready) begin
                dec_valid_d = 1'b0;
            end
            case (state_q)
                ST_LOOKUP: begin
                    if (hit_c) begin
                        if (free_c) begin
                            dec_valid_d = 1'b1;
                            dec_inst_d  = line_data_q[pc_idx_c];
                            dec_pc_d    = pc_q;
                            pc_d        = pc_q + 32'd4;
                        end
                    end else begin
                        mc_en_d = 1'b1;
                        mc_pc_d = pc_q;
                        state_d = ST_MISS;
                    end
                end
                default: begin
                    if (mc_to_if_done) begin
                        mc_en_d = 1'b0;
                        state_d = ST_LOOKUP;
                    end
                end
            endcase
        end
    end

    // Pipeline registers; clr acts even while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOOKUP;
            pc_q        <= RESET_PC;
            mc_en_q     <= 1'b0;
            mc_pc_q     <= 32'h0;
            dec_valid_q <= 1'b0;
            dec_inst_q  <= 32'h0;
            dec_pc_q    <= 32'h0;
        end else if (rdy || clr) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mc_en_q     <= mc_en_d;
            mc_pc_q     <= mc_pc_d;
            dec_valid_q <= dec_valid_d;
            dec_inst_q  <= dec_inst_d;
            dec_pc_q    <= dec_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_q <= '0;
        end else if (fill_we_c) begin
            line_valid_q[fill_idx_c] <= 1'b1;
        end
    end

    // Tag/data arrays need no reset; valid bits gate them
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            line_tag_q[fill_idx_c]  <= fill_tag_c;
            line_data_q[fill_idx_c] <= mc_to_if_result;
        end
    end

    assign if_to_mc_enable = mc_en_q;
    assign if_to_mc_pc     = mc_pc_q;
    assign if_to_dec_valid = dec_valid_q;
    assign if_to_dec_inst  = dec_inst_q;
    assign if_to_dec_pc    = dec_pc_q;

endmodule
